// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the 4-digit 7-segment display arbiter.
//   - owner_e   : who currently owns the display (nobody, background A,
//                 overlay B)
//   - scan_e    : scan FSM state (drive a digit, or the all-off guard gap)
//   - NUM_DIGITS: digits on the board display
//   - ANODE_OFF : anode pattern with every digit switched off (active-low)
//   - lzMask()  : leading-zero mask for a 16-bit snapshot. It is only used
//                 when SEG_LZ_SUPPRESS_EN is defined.
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    typedef enum logic {
        SCAN_DRIVE = 1'b0,
        SCAN_GUARD = 1'b1
    } scan_e;

    // A bit is set for each of digits 3..1 that is zero and has only zeros
    // above it. Digit 0 always stays visible, so bit 0 is never set.
    function automatic logic [3:0] lzMask(input logic [15:0] value);
        logic [3:0] mask;
        mask    = 4'b0000;
        mask[3] = (value[15:12] == 4'h0);
        mask[2] = mask[3] && (value[11:8] == 4'h0);
        mask[1] = mask[2] && (value[7:4] == 4'h0);
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// ---------------------------------------------------------------------------
// seg_scan_timer
// Digit scan sequencer. It steps DRIVE(i) -> GUARD(i) -> DRIVE(i+1) on each
// divider tick, with GUARD_TICKS all-off ticks after each digit slot. It
// flags the tick that leaves slot 3, which is the frame boundary.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   tick              : one-cycle advance enable from the clock divider
//   nextState_o       : scan state after this cycle (DRIVE/GUARD)
//   nextIdx_o         : digit index after this cycle
//   frameBoundary_o   : high on the tick that ends digit 3's slot (guard
//                       included)
//
// The next-state values are exported so that the parent can register its
// display outputs on the same edge that the scan moves. This keeps the
// outputs aligned with the scan position and adds no cycle of lag.
// ---------------------------------------------------------------------------
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned GUARD_TICKS = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tick,
    output scan_e                         nextState_o,
    output logic [$clog2(NUM_DIGITS)-1:0] nextIdx_o,
    output logic                          frameBoundary_o
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // The guard counter counts down to zero, so GUARD_TICKS ticks need a
    // load value of GUARD_TICKS-1.
    localparam logic [3:0] GUARD_LOAD = (GUARD_TICKS > 0) ? 4'(GUARD_TICKS - 1) : 4'd0;

    scan_e            state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       guardCnt_q, guardCnt_d;

    // Next-state logic. Nothing moves without a tick. When GUARD_TICKS is 0,
    // the guard state is skipped and the scan goes straight to the next digit.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        guardCnt_d      = guardCnt_q;
        frameBoundary_o = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN_DRIVE: begin
                    if (GUARD_TICKS > 0) begin
                        state_d    = SCAN_GUARD;
                        guardCnt_d = GUARD_LOAD;
                    end else begin
                        idx_d           = idx_q + IDX_W'(1);
                        frameBoundary_o = (idx_q == LAST_IDX);
                    end
                end
                SCAN_GUARD: begin
                    if (guardCnt_q == 4'd0) begin
                        state_d         = SCAN_DRIVE;
                        idx_d           = idx_q + IDX_W'(1);
                        frameBoundary_o = (idx_q == LAST_IDX);
                    end else begin
                        guardCnt_d = guardCnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = SCAN_DRIVE;
                end
            endcase
        end
    end

    // Scan state register. Reset returns the scan to DRIVE(0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCAN_DRIVE;
            idx_q      <= '0;
            guardCnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            guardCnt_q <= guardCnt_d;
        end
    end

    assign nextState_o = state_d;
    assign nextIdx_o   = idx_d;

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares the 4-digit 7-segment display between a background source (A) and
// an overlay source (B, higher priority). Ownership, the 16-bit snapshot and
// the overlay hold counter change only at frame boundaries. This means each
// frame shows one consistent value.
//
// Parameters
//   HOLD_FRAMES : minimum number of frames that B keeps the display once
//                 granted (1..255)
//   GUARD_TICKS : all-off ticks after each digit slot (0..15)
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   tick                : scan/arbitration advance enable
//   req_a, value_a      : background request and digits ([3:0] = digit 0)
//   req_b, value_b      : overlay request and digits
//   gnt_a, gnt_b        : current owner (one-hot, or both low)
//   an                  : active-low anodes, bit i = digit i
//   digit               : nibble to the 7-seg decoder
//   blank               : decoder must turn all segments off
//   frame_done          : one-cycle pulse on the frame-boundary tick
//
// Configuration
//   SEG_LZ_SUPPRESS_EN  : when defined, leading zeros of the snapshot (digits
//                         3..1) are blanked during their drive slot.
// ---------------------------------------------------------------------------
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 8,
    parameter int unsigned GUARD_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        req_a,
    input  logic [15:0] value_a,
    input  logic        req_b,
    input  logic [15:0] value_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_FRAMES - 1);

    scan_e            nextState;
    logic [IDX_W-1:0] nextIdx;
    logic             frameBoundary;

    owner_e      owner_q, owner_d;
    logic [7:0]  holdCnt_q, holdCnt_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic        gntA_d, gntB_d, blank_d, frameDone_d;
    logic [3:0]  an_d, digit_d;
`ifdef SEG_LZ_SUPPRESS_EN
    logic [3:0]  lzMask_q, lzMask_d;
`endif

    seg_scan_timer #(
        .GUARD_TICKS (GUARD_TICKS)
    ) scanTimer (
        .clk             (clk),
        .reset_n         (reset_n),
        .tick            (tick),
        .nextState_o     (nextState),
        .nextIdx_o       (nextIdx),
        .frameBoundary_o (frameBoundary)
    );

    // Arbitration at the frame boundary. A held overlay keeps the display
    // regardless of requests. Otherwise B beats A. The hold count is reloaded
    // only when B is newly granted, and it runs down to zero while B stays.
    // The snapshot is refreshed only from a requester that is actively
    // asking. A granted owner with a dropped request keeps its old digits.
    always_comb begin
        owner_d    = owner_q;
        holdCnt_d  = holdCnt_q;
        snapshot_d = snapshot_q;
        if (frameBoundary) begin
            if (owner_q == OWN_B && holdCnt_q != 8'd0) begin
                owner_d   = OWN_B;
                holdCnt_d = holdCnt_q - 8'd1;
            end else if (req_b) begin
                owner_d   = OWN_B;
                holdCnt_d = (owner_q != OWN_B) ? HOLD_LOAD : 8'd0;
            end else if (req_a) begin
                owner_d = OWN_A;
            end else begin
                owner_d = OWN_NONE;
            end

            if (owner_d == OWN_A && req_a) begin
                snapshot_d = value_a;
            end else if (owner_d == OWN_B && req_b) begin
                snapshot_d = value_b;
            end
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    // The suppression mask follows the snapshot. It is computed once at load
    // time, not on every drive slot.
    always_comb begin
        lzMask_d = lzMask_q;
        if (frameBoundary) begin
            lzMask_d = lzMask(snapshot_d);
        end
    end
`endif

    // Output values are built from the post-edge scan position, owner and
    // snapshot. At a boundary, digit 0 of the new owner is therefore
    // registered on the same edge as the grant.
    always_comb begin
        gntA_d      = (owner_d == OWN_A);
        gntB_d      = (owner_d == OWN_B);
        frameDone_d = frameBoundary;
        digit_d     = snapshot_d[{nextIdx, 2'b00} +: 4];
        an_d        = ANODE_OFF;
        blank_d     = 1'b1;
        if (owner_d != OWN_NONE && nextState == SCAN_DRIVE) begin
            an_d    = ~(4'b0001 << nextIdx);
`ifdef SEG_LZ_SUPPRESS_EN
            blank_d = lzMask_d[nextIdx];
`else
            blank_d = 1'b0;
`endif
        end
    end

    // State and output registers. Reset clears them immediately, without
    // waiting for a clock edge, so the display goes dark at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= OWN_NONE;
            holdCnt_q  <= 8'd0;
            snapshot_q <= 16'h0000;
`ifdef SEG_LZ_SUPPRESS_EN
            lzMask_q   <= 4'b0000;
`endif
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            an         <= ANODE_OFF;
            digit      <= 4'h0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            holdCnt_q  <= holdCnt_d;
            snapshot_q <= snapshot_d;
`ifdef SEG_LZ_SUPPRESS_EN
            lzMask_q   <= lzMask_d;
`endif
            gnt_a      <= gntA_d;
            gnt_b      <= gntB_d;
            an         <= an_d;
            digit      <= digit_d;
            blank      <= blank_d;
            frame_done <= frameDone_d;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
// Directed bench for seg_display_arbiter at default parameters
// (HOLD_FRAMES = 8, GUARD_TICKS = 1, so one frame is 8 ticks). Every tick is
// a single-cycle pulse. Outputs are sampled on the falling edge after the
// tick's rising edge. The leading-zero phase expects blanking only when
// SEG_LZ_SUPPRESS_EN is defined.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        req_a = 1'b0;
    logic [15:0] value_a = 16'h0;
    logic        req_b = 1'b0;
    logic [15:0] value_b = 16'h0;
    logic        gnt_a, gnt_b, blank, frame_done;
    logic [3:0]  an, digit;

    int checkCount = 0;
    int errorCount = 0;

`ifdef SEG_LZ_SUPPRESS_EN
    localparam logic LZ_ON = 1'b1;
`else
    localparam logic LZ_ON = 1'b0;
`endif

    seg_display_arbiter #(
        .HOLD_FRAMES (8),
        .GUARD_TICKS (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .req_a      (req_a),
        .value_a    (value_a),
        .req_b      (req_b),
        .value_b    (value_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .an         (an),
        .digit      (digit),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if observed and expected differ.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic [15:0] va, input logic rb, input logic [15:0] vb);
        req_a   = ra;
        value_a = va;
        req_b   = rb;
        value_b = vb;
    endtask

    // One divider tick. The task returns on the falling edge after the tick
    // is captured, so the outputs of that tick are stable.
    task automatic tickOnce();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tickOnce();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        tick    = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [3:0] anSeq [8] = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
    logic [3:0] digSeq [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        // Reset values, checked while reset is asserted.
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_an", 16'(an), 16'hF);
        checkOutput("rst_digit", 16'(digit), 16'h0);
        checkOutput("rst_blank", 16'(blank), 16'h1);
        checkOutput("rst_gnt_a", 16'(gnt_a), 16'h0);
        checkOutput("rst_gnt_b", 16'(gnt_b), 16'h0);
        checkOutput("rst_frame_done", 16'(frame_done), 16'h0);
        reset_n = 1'b1;

        // Phase 1: A alone. It gets the grant at the first boundary, then
        // the display scans 1234.
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0);
        for (int i = 0; i < 7; i++) begin
            tickOnce();
            checkOutput("pre_grant_an", 16'(an), 16'hF);
            checkOutput("pre_grant_gnt_a", 16'(gnt_a), 16'h0);
        end
        tickOnce();
        checkOutput("grant_a", 16'(gnt_a), 16'h1);
        checkOutput("grant_a_gnt_b", 16'(gnt_b), 16'h0);
        checkOutput("grant_frame_done", 16'(frame_done), 16'h1);
        checkOutput("grant_an", 16'(an), 16'hE);
        checkOutput("grant_digit", 16'(digit), 16'h4);
        checkOutput("grant_blank", 16'(blank), 16'h0);
        @(negedge clk);
        checkOutput("frame_done_pulse", 16'(frame_done), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            tickOnce();
            checkOutput("scan_an", 16'(an), 16'(anSeq[i % 8]));
            if ((i % 2) == 0) begin
                checkOutput("scan_digit", 16'(digit), 16'(digSeq[(i % 8) / 2]));
                checkOutput("scan_blank", 16'(blank), 16'h0);
            end else begin
                checkOutput("guard_blank", 16'(blank), 16'h1);
            end
        end

        // Phase 2: a short B pulse mid-frame is ignored. B held over the
        // boundary wins, holds for 8 frames, and then A returns.
        ticks(3);
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'hBEEF);
        tickOnce();
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'hBEEF);
        ticks(4);
        checkOutput("pulse_gnt_a", 16'(gnt_a), 16'h1);
        checkOutput("pulse_gnt_b", 16'(gnt_b), 16'h0);
        checkOutput("pulse_digit", 16'(digit), 16'h4);
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'hBEEF);
        ticks(8);
        checkOutput("b_grant_gnt_b", 16'(gnt_b), 16'h1);
        checkOutput("b_grant_gnt_a", 16'(gnt_a), 16'h0);
        checkOutput("b_grant_an", 16'(an), 16'hE);
        checkOutput("b_grant_digit", 16'(digit), 16'hF);
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0000);
        ticks(2);
        checkOutput("b_d1_an", 16'(an), 16'hD);
        checkOutput("b_d1_digit", 16'(digit), 16'hE);
        ticks(6);
        checkOutput("b_hold_gnt_b", 16'(gnt_b), 16'h1);
        checkOutput("b_hold_digit", 16'(digit), 16'hF);
        for (int f = 2; f <= 7; f++) begin
            ticks(8);
            checkOutput("b_hold_gnt_b", 16'(gnt_b), 16'h1);
            checkOutput("b_hold_digit", 16'(digit), 16'hF);
        end
        ticks(8);
        checkOutput("a_return_gnt_a", 16'(gnt_a), 16'h1);
        checkOutput("a_return_gnt_b", 16'(gnt_b), 16'h0);
        checkOutput("a_return_digit", 16'(digit), 16'h4);

        // Phase 3: A and B both request before the first boundary, and B wins.
        doReset();
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'hBEEF);
        ticks(8);
        checkOutput("both_gnt_b", 16'(gnt_b), 16'h1);
        checkOutput("both_gnt_a", 16'(gnt_a), 16'h0);
        checkOutput("both_digit", 16'(digit), 16'hF);

        // Phase 4: with no requests, the display stays dark and frame_done
        // still pulses every 8 ticks.
        doReset();
        for (int i = 0; i < 16; i++) begin
            tickOnce();
            checkOutput("idle_an", 16'(an), 16'hF);
            checkOutput("idle_blank", 16'(blank), 16'h1);
            checkOutput("idle_frame_done", 16'(frame_done), (i % 8 == 7) ? 16'h1 : 16'h0);
        end
        checkOutput("idle_gnt_a", 16'(gnt_a), 16'h0);
        checkOutput("idle_gnt_b", 16'(gnt_b), 16'h0);

        // Phase 5: reset is asserted during digit 2. The outputs clear with
        // no clock edge, and the scan restarts at digit 0.
        doReset();
        applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0);
        ticks(12);
        checkOutput("mid_d2_an", 16'(an), 16'hB);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_an", 16'(an), 16'hF);
        checkOutput("async_rst_gnt_a", 16'(gnt_a), 16'h0);
        checkOutput("async_rst_blank", 16'(blank), 16'h1);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(4);
        checkOutput("restart_gnt_a", 16'(gnt_a), 16'h0);
        ticks(4);
        checkOutput("restart_grant", 16'(gnt_a), 16'h1);
        checkOutput("restart_an", 16'(an), 16'hE);
        checkOutput("restart_digit", 16'(digit), 16'h4);

        // Phase 6: leading zeros. They are blanked only when suppression is
        // built in.
        doReset();
        applyStimulus(1'b1, 16'h0050, 1'b0, 16'h0);
        ticks(8);
        checkOutput("lz_d0_an", 16'(an), 16'hE);
        checkOutput("lz_d0_digit", 16'(digit), 16'h0);
        checkOutput("lz_d0_blank", 16'(blank), 16'h0);
        ticks(2);
        checkOutput("lz_d1_digit", 16'(digit), 16'h5);
        checkOutput("lz_d1_blank", 16'(blank), 16'h0);
        ticks(2);
        checkOutput("lz_d2_an", 16'(an), 16'hB);
        checkOutput("lz_d2_blank", 16'(blank), 16'(LZ_ON));
        ticks(2);
        checkOutput("lz_d3_an", 16'(an), 16'h7);
        checkOutput("lz_d3_blank", 16'(blank), 16'(LZ_ON));
        applyStimulus(1'b1, 16'h0000, 1'b0, 16'h0);
        ticks(2);
        checkOutput("lz0_d0_an", 16'(an), 16'hE);
        checkOutput("lz0_d0_blank", 16'(blank), 16'h0);
        ticks(2);
        checkOutput("lz0_d1_an", 16'(an), 16'hD);
        checkOutput("lz0_d1_blank", 16'(blank), 16'(LZ_ON));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Sequences and shares the board's 4-digit 7-segment display between two requesters: a background source (math result) and an overlay source (status/message). It sits between the clock divider and the 7-seg decoder in `top`. It scans one digit per divider tick with an optional blanking guard, and drives active-low anodes plus a nibble/blank pair to the decoder. Ownership changes only at frame boundaries, so every frame shows one consistent 16-bit snapshot.

## Interface
- `HOLD_FRAMES`, default 8: minimum full frames the overlay (B) keeps the display once granted; legal range 1..255.
- `GUARD_TICKS`, default 1: all-anodes-off ticks inserted after each digit slot; legal range 0..15.
- `clk` in 1: 100 MHz board clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle enable pulse from the clock divider; all scan/arbitration state advances only on `tick`.
- `req_a` in 1: background request.
- `value_a` in 16: background digits; [3:0] is digit 0 (rightmost).
- `req_b` in 1: overlay request; has priority over A.
- `value_b` in 16: overlay digits.
- `gnt_a`, `gnt_b` out 1 each: current owner, one-hot or both 0.
- `an` out 4: anodes, active-low; bit i drives digit i.
- `digit` out 4: nibble to the decoder.
- `blank` out 1: decoder must turn all segments off.
- `frame_done` out 1: one-cycle pulse on the tick that ends digit 3's slot, including its guard.

## Operation
- Scan FSM states:
  - DRIVE(i): `an` = ~(1<<i), `digit` = snapshot[4i+3:4i].
  - GUARD(i): `an` = 4'hF, `blank` = 1, runs for GUARD_TICKS ticks.
- Transitions:
  - DRIVE(i) → GUARD(i) on tick if GUARD_TICKS>0, else → DRIVE((i+1) mod 4).
  - GUARD(i) → DRIVE((i+1) mod 4) on the tick that exhausts the guard counter.
  - Index wraps 3→0.
- A frame boundary is the tick leaving slot 3. The following happen at the frame boundary, and only there:
  - Owner update.
  - Snapshot load.
  - hold_cnt update.
- Owner states: NONE, A, B. Next owner at a boundary:
  - If owner==B and hold_cnt>0: stay B.
  - Else if req_b: B, with hold_cnt reloaded to HOLD_FRAMES-1 when entering B from another owner.
  - Else if req_a: A.
  - Else NONE.
- While owner stays B, hold_cnt decrements at each boundary and saturates at 0.
- Snapshot loads the new owner's value only if that owner's req is high; otherwise the previous snapshot is kept.
- Owner NONE: scan keeps running, `an` = 4'hF, `blank` = 1.
- Simultaneous `req_a` and `req_b` at a boundary: B wins.
- B drops req during hold: B stays granted and displays its last snapshot until hold expires.
- A's request rising while B holds is ignored until the hold expires.

## Timing
- All outputs are registered.
- Reset values:
  - `an` = 4'hF, `digit` = 0, `blank` = 1, `gnt_a` = `gnt_b` = 0, `frame_done` = 0.
  - Internal: FSM = DRIVE(0), owner NONE, hold_cnt = 0, snapshot = 0.
- `gnt_*`, `frame_done` and the new snapshot update on the clock edge of the boundary tick. Digit 0 of the new owner appears in that same edge's outputs.
- Frame length: 4×(1+GUARD_TICKS) ticks.
- Worst-case request-to-grant (B, no hold pending): one frame.
- `value_*` may change at any time; only the boundary sample is used.
- `reset_n` asserted mid-frame: all state returns to reset values immediately, with no wait for a clock edge.
- Release is synchronized to `clk`.

## Configuration
- `SEG_LZ_SUPPRESS_EN` defined:
  - Leading-zero suppression applies to the snapshot.
  - Digits 3..1 that are zero and have only zeros above them force `blank` = 1 during their DRIVE slot, with the anode still asserted.
  - Digit 0 is never suppressed.
  - Suppression is computed from the snapshot at load time and stored as a 4-bit mask.
- Undefined: all four digits are always displayed; no suppression logic is present.

## Structure
- Package `seg_pkg` holds:
  - The owner enum (NONE/A/B).
  - `NUM_DIGITS` = 4.
  - `ANODE_OFF` = 4'hF.
  - The scan-state enum (DRIVE/GUARD).
- One sub-module, `seg_scan_timer`, owns the DRIVE/GUARD FSM, the digit index and the guard counter, and emits `frame_boundary`.
- The arbiter, snapshot, hold counter and output registers live in the top of this block.

## Test plan
- Reset, then `req_a` = 1, `value_a` = 16'h1234, GUARD_TICKS = 1 → `gnt_a` at first boundary; `an` sequence E,F,D,F,B,F,7,F with `digit` 4,3,2,1 on the drive slots.
- A owning, `req_b` pulses high for 1 tick mid-frame with `value_b` = 16'hBEEF → no change; `req_b` held through the boundary → `gnt_b`, then exactly HOLD_FRAMES=8 frames of BEEF, then A returns.
- `req_a` and `req_b` both rise before the first boundary → `gnt_b` = 1, `gnt_a` = 0.
- No requests → `an` = 4'hF and `blank` = 1 continuously, while `frame_done` still pulses every 8 ticks.
- `reset_n` low during digit 2 → `an` = 4'hF, gnts 0 and `blank` = 1 asynchronously; after release, scan restarts at digit 0.
- With `SEG_LZ_SUPPRESS_EN`, `value_a` = 16'h0050 → digits 3,2 blanked, digits 1,0 show 5,0; `value_a` = 16'h0000 → only digit 0 shown.
